// File: rtl/note_pkg.sv
// Shared note codes for the key encoder and the segment display.
// Pure definitions: no latency, no flow control.
package note_pkg;

  localparam int NUM_KEYS = 7;

  typedef logic [2:0] note_t;

  localparam note_t NOTE_NONE = 3'd0;
  localparam note_t NOTE_C    = 3'd1;
  localparam note_t NOTE_D    = 3'd2;
  localparam note_t NOTE_E    = 3'd3;
  localparam note_t NOTE_F    = 3'd4;
  localparam note_t NOTE_G    = 3'd5;
  localparam note_t NOTE_A    = 3'd6;
  localparam note_t NOTE_B    = 3'd7;

  // Key index 0..6 maps onto codes C..B.
  function automatic note_t key_to_note(input int idx);
    return note_t'(idx + 1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchronizer, then a level must persist DEBOUNCE_CYCLES edges to flip key_db.
// Latency 2 + DEBOUNCE_CYCLES edges; free-running, no backpressure.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_db
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      key_db <= 1'b0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      // Any return to the debounced level restarts the count, so glitches never accumulate.
      if (sync2 == key_db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt    <= '0;
        key_db <= ~key_db;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/note_key_encoder.sv
// Debounced 7-key piano to registered note code; lowest key wins. Define NOTE_KEY_HOLD_EN to sustain the last note.
// Latency 2 + DEBOUNCE_CYCLES + 1 edges from raw key to note; no backpressure.
module note_key_encoder
  import note_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys,
  output note_t               note,
  output logic                note_valid,
  output logic                note_change
);

  logic [NUM_KEYS-1:0] key_db;
  note_t               enc_note;
  note_t               next_note;
  logic                any_key;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk    (clk),
      .rst    (rst),
      .key_raw(keys[k]),
      .key_db (key_db[k])
    );
  end

  // Scan from the top so the lowest pressed index is the last write.
  always_comb begin
    enc_note = NOTE_NONE;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key_db[i]) enc_note = key_to_note(i);
    end
  end

  assign any_key = |key_db;

  always_comb begin
`ifdef NOTE_KEY_HOLD_EN
    next_note = any_key ? enc_note : note;
`else
    next_note = enc_note;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      note        <= NOTE_NONE;
      note_valid  <= 1'b0;
      note_change <= 1'b0;
    end else begin
      note        <= next_note;
      note_valid  <= any_key;
      note_change <= (next_note != note);
    end
  end

endmodule

// File: tb/tb_note_key_encoder.sv
// Directed and random stimulus for note_key_encoder against a history-window reference model.
module tb_note_key_encoder;
  import note_pkg::*;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] keys;
  logic [6:0] keys2;
  note_t      note;
  note_t      note2;
  logic       note_valid, note_change;
  logic       nv2, nc2;

  int n_assert = 0;
  int n_fail   = 0;
  int pulses;
  note_t saved;

  always #5 clk = ~clk;

  note_key_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .keys(keys),
    .note(note), .note_valid(note_valid), .note_change(note_change)
  );

  note_key_encoder #(.DEBOUNCE_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .keys(keys2),
    .note(note2), .note_valid(nv2), .note_change(nc2)
  );

  // Reference model: keys sampled per edge, synchronized level is the sample two edges back,
  // a debounced bit flips once its last D synchronized levels all disagree with it.
  logic [6:0] raw_q[$];
  logic [6:0] lvl_q[$];
  logic [6:0] db_m;
  note_t      exp_note;
  logic       exp_valid, exp_change;

  function automatic note_t prio(input logic [6:0] v);
    for (int i = 0; i < 7; i++) if (v[i]) return note_t'(i + 1);
    return 3'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [6:0] sl;
    note_t      nn;
    bit         flip;
    if (rst) begin
      raw_q.delete();
      lvl_q.delete();
      db_m       = '0;
      exp_note   = 3'd0;
      exp_valid  = 1'b0;
      exp_change = 1'b0;
      return;
    end
    nn = prio(db_m);
`ifdef NOTE_KEY_HOLD_EN
    if (db_m == 7'd0) nn = exp_note;
`endif
    exp_change = (nn != exp_note);
    exp_note   = nn;
    exp_valid  = (db_m != 7'd0);
    sl = (raw_q.size() >= 2) ? raw_q[raw_q.size() - 2] : 7'd0;
    raw_q.push_back(keys);
    if (raw_q.size() > 4) void'(raw_q.pop_front());
    lvl_q.push_back(sl);
    if (lvl_q.size() > D) void'(lvl_q.pop_front());
    if (lvl_q.size() == D) begin
      for (int i = 0; i < 7; i++) begin
        flip = 1'b1;
        foreach (lvl_q[j]) if (lvl_q[j][i] == db_m[i]) flip = 1'b0;
        if (flip) db_m[i] = ~db_m[i];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("note", 32'(note), 32'(exp_note));
    check("note_valid", 32'(note_valid), 32'(exp_valid));
    check("note_change", 32'(note_change), 32'(exp_change));
    if (note_change === 1'b1) pulses++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst   = 1'b1;
    keys  = '0;
    keys2 = '0;
    tick();
    check("rst_note", 32'(note), 0);
    check("rst_valid", 32'(note_valid), 0);
    check("rst_change", 32'(note_change), 0);
    check("rst_note2", 32'(note2), 0);
    rst = 1'b0;
    ticks(2);

    // All keys at once on the DEBOUNCE_CYCLES=2 instance: C after 5 edges, one pulse.
    keys2 = 7'h7F;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check("d2_note", 32'(note2), (e < 5) ? 0 : 1);
      check("d2_change", 32'(nc2), (e == 5) ? 1 : 0);
    end

    // Single key E: code 3 exactly 7 edges later.
    keys = 7'b0000100;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 6) check("e_note_early", 32'(note), 0);
      if (e == 7) begin
        check("e_note", 32'(note), 3);
        check("e_valid", 32'(note_valid), 1);
        check("e_change", 32'(note_change), 1);
      end
      if (e == 8) check("e_change_once", 32'(note_change), 0);
    end
    keys = '0;
    ticks(10);

    // 3-cycle glitch on D is filtered.
    saved  = note;
    pulses = 0;
    keys   = 7'b0000010;
    ticks(3);
    keys = '0;
    ticks(10);
    check("glitch_note", 32'(note), 32'(saved));
    check("glitch_pulses", pulses, 0);

    // Held B, then C overrides, then back to B.
    keys = 7'b1000000;
    ticks(9);
    check("b_note", 32'(note), 7);
    pulses = 0;
    keys   = 7'b1000001;
    ticks(9);
    check("c_over_b", 32'(note), 1);
    check("c_over_b_pulses", pulses, 1);
    pulses = 0;
    keys   = 7'b1000000;
    ticks(9);
    check("back_to_b", 32'(note), 7);
    check("back_to_b_pulses", pulses, 1);
    pulses = 0;
    ticks(20);
    check("held_no_pulse", pulses, 0);
    keys = '0;
    ticks(10);

    // Reset with G mid-debounce (counter at 2), key held through reset.
    keys = 7'b0010000;
    ticks(4);
    rst = 1'b1;
    tick();
    check("mid_rst_note", 32'(note), 0);
    check("mid_rst_change", 32'(note_change), 0);
    rst    = 1'b0;
    pulses = 0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 6) begin
        check("post_rst_quiet", pulses, 0);
        check("post_rst_note_early", 32'(note), 0);
      end
      if (e == 7) begin
        check("post_rst_note", 32'(note), 5);
        check("post_rst_change", 32'(note_change), 1);
      end
    end
    keys = '0;
    ticks(10);

    // Release all from D: cleared or sustained depending on build.
    keys = 7'b0000010;
    ticks(9);
    check("d_note", 32'(note), 2);
    keys = '0;
    ticks(6);
    tick();
`ifdef NOTE_KEY_HOLD_EN
    check("rel_note", 32'(note), 2);
    check("rel_change", 32'(note_change), 0);
`else
    check("rel_note", 32'(note), 0);
    check("rel_change", 32'(note_change), 1);
`endif
    check("rel_valid", 32'(note_valid), 0);

    // Random segments, mostly sparse key sets with varied hold lengths and rare resets.
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) keys = 7'($urandom_range(0, 127));
      else keys = 7'($urandom_range(0, 127) & $urandom_range(0, 127));
      ticks($urandom_range(1, 9));
    end
    keys = '0;
    ticks(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
